// File: rtl/usb_serial_in_packetizer_if.sv
// Byte-stream and PE endpoint-put signals of one bulk IN packetizer.
// master = packetizer side, slave = source FIFO plus PE endpoint side.
interface usb_serial_in_packetizer_if;
   logic       src_valid;
   logic [7:0] src_data;
   logic       src_ready;
   logic       in_ep_data_free;
   logic       in_ep_acked;
   logic       in_ep_data_put;
   logic [7:0] in_ep_data;
   logic       in_ep_data_done;

   modport master (
      input  src_valid, src_data, in_ep_data_free, in_ep_acked,
      output src_ready, in_ep_data_put, in_ep_data, in_ep_data_done
   );

   modport slave (
      output src_valid, src_data, in_ep_data_free, in_ep_acked,
      input  src_ready, in_ep_data_put, in_ep_data, in_ep_data_done
   );
endinterface

// File: rtl/usb_serial_in_packetizer.sv
// Drains a byte stream into one IN endpoint of usb_fs_in_pe and decides packet
// boundaries: full packet at MAX_PKT bytes, short packet on idle timeout or flush.
// Optional feature macro: USB_IN_ZLP_EN -- sends a zero-length packet after a
// full packet that is followed by idle time (or by a flush).
module usb_serial_in_packetizer #(
   parameter int MAX_PKT        = 32,
   parameter int TIMEOUT_CYCLES = 4800
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      ep_reset,
   input  logic                      flush,
   output logic                      busy,
   usb_serial_in_packetizer_if.master ep
);
   localparam int CNT_W = $clog2(MAX_PKT + 1);
   localparam int TMR_W = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(MAX_PKT);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MAX_PKT - 1);
   localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      FILL     = 2'd0,
      DONE     = 2'd1,
      WAIT_ACK = 2'd2
   } state_t;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] byte_cnt_reg, byte_cnt_next;
   logic [TMR_W-1:0] timer_reg, timer_next;
   logic             zlp_pending_reg, zlp_pending_next;
`ifdef USB_IN_ZLP_EN
   logic             last_full_reg, last_full_next;
`endif
   logic             accept;
   logic             put;
   logic             done;
   logic             has_data;

   // Data passes straight through; the PE write happens in the same cycle the byte is popped.
   assign ep.in_ep_data      = ep.src_data;
   assign ep.src_ready       = accept;
   assign ep.in_ep_data_put  = put;
   assign ep.in_ep_data_done = done;
   assign busy               = (state_reg != FILL) || (byte_cnt_reg != '0);

   // Next-state and handshake outputs; strobes are forced low while either reset is active
   // so no byte is popped from the source and then discarded.
   always_comb begin
      state_next       = state_reg;
      byte_cnt_next    = byte_cnt_reg;
      timer_next       = timer_reg;
      zlp_pending_next = zlp_pending_reg;
`ifdef USB_IN_ZLP_EN
      last_full_next   = last_full_reg;
`endif
      accept           = 1'b0;
      put              = 1'b0;
      done             = 1'b0;
      has_data         = 1'b0;

      case (state_reg)
         FILL: begin
            accept   = ep.in_ep_data_free && (byte_cnt_reg < CNT_FULL) && !reset && !ep_reset;
            put      = accept && ep.src_valid;
            has_data = put || (byte_cnt_reg != '0) || zlp_pending_reg;
            if (put) begin
               byte_cnt_next    = byte_cnt_reg + 1'b1;
               timer_next       = '0;
               zlp_pending_next = 1'b0;
            end else if (((byte_cnt_reg != '0) || zlp_pending_reg) && (timer_reg != TMR_LIMIT)) begin
               timer_next = timer_reg + 1'b1;
            end
            if ((put && (byte_cnt_reg == CNT_LAST)) || (flush && has_data) || (timer_reg == TMR_LIMIT)) begin
               state_next = DONE;
            end
         end
         DONE: begin
            done = !reset && !ep_reset;
`ifdef USB_IN_ZLP_EN
            last_full_next = (byte_cnt_reg == CNT_FULL);
`endif
            byte_cnt_next    = '0;
            timer_next       = '0;
            zlp_pending_next = 1'b0;
            state_next       = WAIT_ACK;
         end
         WAIT_ACK: begin
            // Writes stay blocked until the host ACK; retries are the PE's business.
            if (ep.in_ep_acked) begin
               state_next = FILL;
`ifdef USB_IN_ZLP_EN
               zlp_pending_next = last_full_reg;
`endif
            end
         end
         default: state_next = FILL;
      endcase
   end

   // State and counters; ep_reset behaves like reset but synchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg       <= FILL;
         byte_cnt_reg    <= '0;
         timer_reg       <= '0;
         zlp_pending_reg <= 1'b0;
`ifdef USB_IN_ZLP_EN
         last_full_reg   <= 1'b0;
`endif
      end else if (ep_reset) begin
         state_reg       <= FILL;
         byte_cnt_reg    <= '0;
         timer_reg       <= '0;
         zlp_pending_reg <= 1'b0;
`ifdef USB_IN_ZLP_EN
         last_full_reg   <= 1'b0;
`endif
      end else begin
         state_reg       <= state_next;
         byte_cnt_reg    <= byte_cnt_next;
         timer_reg       <= timer_next;
         zlp_pending_reg <= zlp_pending_next;
`ifdef USB_IN_ZLP_EN
         last_full_reg   <= last_full_next;
`endif
      end
   end
endmodule
